// File: rtl/rv_dbg_pkg.sv
// Shared types and helpers for the debug-path store tracer.
//   conv_state_t  : state encoding of the sequential binary-to-BCD converter
//   BCD_ADD3      : correction added to a BCD digit before each doubling step
//   bcd_adjust()  : per-digit double-dabble correction (add 3 when digit >= 5)
package rv_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam logic [3:0] BCD_ADD3   = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd5;

  // A digit of 5..9 doubles past 9, so pre-add 3 to make the shift carry out.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    logic [3:0] result;
    if (digit >= BCD_THRESH) begin
      result = digit + BCD_ADD3;
    end else begin
      result = digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add (double-dabble) binary-to-BCD converter.
// One input bit is consumed per cycle in SHIFT; the result register changes
// only in DONE so a downstream display never sees partial values.
// Digits above DIGITS are carried out of the top and lost, so the result is
// the input value modulo 10^DIGITS.
// Ports:
//   clk, reset : clock, synchronous active-high reset (aborts a conversion)
//   start      : request; accepted in IDLE or DONE (back-to-back restart)
//   bin        : value sampled in LOAD
//   busy       : high from LOAD through DONE
//   done       : high during the DONE cycle
//   bcd        : registered result, digit 0 in [3:0]
module bin2bcd_seq
  import rv_dbg_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);

  conv_state_t       state_r;
  conv_state_t       state_s;
  logic [IN_W-1:0]   bin_r;
  logic [BCD_W-1:0]  work_r;
  logic [BCD_W-1:0]  adj_s;
  logic [BCD_W-1:0]  bcd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_shift_s;

  assign last_shift_s = (cnt_r == LAST_BIT);

  // Per-digit add-3 correction applied before every shift.
  always_comb begin
    adj_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj_s[4*d +: 4] = bcd_adjust(work_r[4*d +: 4]);
    end
  end

  // Converter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Converter next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = SHIFT;
      end
      SHIFT: begin
        if (last_shift_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        // A request waiting at DONE restarts without passing through IDLE.
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Conversion datapath: sample, shift MSB-first into the BCD digits, publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_r  <= '0;
      work_r <= '0;
      cnt_r  <= '0;
      bcd_r  <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          bin_r  <= bin;
          work_r <= '0;
          cnt_r  <= '0;
        end
        SHIFT: begin
          work_r <= {adj_s[BCD_W-2:0], bin_r[IN_W-1]};
          bin_r  <= {bin_r[IN_W-2:0], 1'b0};
          cnt_r  <= cnt_r + 1'b1;
        end
        DONE: begin
          bcd_r <= work_r;
        end
        default: begin
          bcd_r <= bcd_r;
        end
      endcase
    end
  end

  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);
  assign bcd  = bcd_r;

endmodule

// File: rtl/store_trace_display.sv
// Store-event tracer for the core debug path.
// Every data-memory write leaves (addr, data) low bits in a DEPTH-entry trace.
// The selected entry (newest, or older ones in browse view) is converted to
// BCD for 7-segment decoders by two lockstep bin2bcd_seq instances.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mem_write             : store strobe, one cycle per store
//   data_addr, write_data : store address and data
//   clear                 : empty the trace and clear overflow
//   browse                : 0 live view (newest), 1 browse view
//   step                  : select next-older entry in browse view
//   addr_bcd, data_bcd    : BCD of the displayed entry
//   entry_valid           : trace holds at least one entry
//   count                 : entries held, saturating at DEPTH
//   overflow              : sticky, a store was lost or overwritten
//   busy                  : conversion in progress
module store_trace_display
  import rv_dbg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CAP_W       = 10,
  parameter int DEPTH       = 8,
  parameter int ADDR_DIGITS = 3,
  parameter int DATA_DIGITS = 3,
  parameter int OVERWRITE   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_write,
  input  logic [DATA_WIDTH-1:0]       data_addr,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        clear,
  input  logic                        browse,
  input  logic                        step,
  output logic [4*ADDR_DIGITS-1:0]    addr_bcd,
  output logic [4*DATA_DIGITS-1:0]    data_bcd,
  output logic                        entry_valid,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic             OVW_EN     = (OVERWRITE != 0);

  logic [CAP_W-1:0] addr_mem_r [DEPTH];
  logic [CAP_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic [PTR_W-1:0] offset_r;
  logic             browse_d_r;
  logic             pending_r;

  logic             store_s;
  logic             full_s;
  logic             capture_s;
  logic             step_ok_s;
  logic             offset_last_s;
  logic             req_s;
  logic             start_s;
  logic             accept_s;
  logic [PTR_W-1:0] sel_ptr_s;
  logic [CAP_W-1:0] sel_addr_s;
  logic [CAP_W-1:0] sel_data_s;
  logic             addr_busy_s;
  logic             data_busy_s;
  logic             addr_done_s;
  logic             data_done_s;
  logic             conv_busy_s;
  logic             conv_done_s;

  // clear takes priority, so a store in the same cycle never lands.
  assign store_s       = mem_write & ~clear;
  assign full_s        = (count_r == FULL_COUNT);
  assign capture_s     = store_s & (~full_s | OVW_EN);
  assign step_ok_s     = browse & step & (count_r != '0);
  assign offset_last_s = ({1'b0, offset_r} == (count_r - CNT_W'(1)));

  // Any event that can change what should be on the display asks for a refresh.
  assign req_s = (~browse & capture_s) | step_ok_s | (browse_d_r & ~browse) | clear;

  assign conv_busy_s = addr_busy_s | data_busy_s;
  assign conv_done_s = addr_done_s & data_done_s;
  assign start_s     = req_s | pending_r;
  assign accept_s    = start_s & (~conv_busy_s | conv_done_s);

  // Newest entry sits just behind the write pointer; older ones further back.
  assign sel_ptr_s = wr_ptr_r - PTR_W'(1) - offset_r;

  // Selected entry, forced to zero while the trace is empty.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    if (count_r != '0) begin
      sel_addr_s = addr_mem_r[sel_ptr_s];
      sel_data_s = data_mem_r[sel_ptr_s];
    end else begin
      sel_addr_s = '0;
      sel_data_s = '0;
    end
  end

  // Trace storage; contents are don't-care while count says they are absent.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      addr_mem_r[wr_ptr_r] <= data_addr[CAP_W-1:0];
      data_mem_r[wr_ptr_r] <= write_data[CAP_W-1:0];
    end else begin
      addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
    end
  end

  // Trace bookkeeping: write pointer, fill count, overflow and browse offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      offset_r   <= '0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      offset_r   <= '0;
    end else begin
      if (capture_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (!full_s) begin
          count_r <= count_r + CNT_W'(1);
        end
      end
      // Full trace: the store either overwrites the oldest entry or is dropped.
      if (store_s && full_s) begin
        overflow_r <= 1'b1;
      end
      if (!browse) begin
        offset_r <= '0;
      end else if (step_ok_s) begin
        if (offset_last_s) begin
          offset_r <= '0;
        end else begin
          offset_r <= offset_r + PTR_W'(1);
        end
      end
    end
  end

  // Browse level history for the leave-browse refresh, plus coalesced request.
  always_ff @(posedge clk) begin
    if (reset) begin
      browse_d_r <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      browse_d_r <= browse;
      pending_r  <= (pending_r | req_s) & ~accept_s;
    end
  end

  bin2bcd_seq #(
    .IN_W   (CAP_W),
    .DIGITS (ADDR_DIGITS)
  ) u_addr_conv (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .bin   (sel_addr_s),
    .busy  (addr_busy_s),
    .done  (addr_done_s),
    .bcd   (addr_bcd)
  );

  bin2bcd_seq #(
    .IN_W   (CAP_W),
    .DIGITS (DATA_DIGITS)
  ) u_data_conv (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .bin   (sel_data_s),
    .busy  (data_busy_s),
    .done  (data_done_s),
    .bcd   (data_bcd)
  );

  generate
    if (CAP_W < DATA_WIDTH) begin : g_unused_hi
      logic unused_hi_s;
      assign unused_hi_s = ^{data_addr[DATA_WIDTH-1:CAP_W], write_data[DATA_WIDTH-1:CAP_W]};
    end
  endgenerate

  assign entry_valid = (count_r != '0);
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign busy        = conv_busy_s;

endmodule

// File: tb/tb_store_trace_display.sv
module tb_store_trace_display;

  localparam int CAP_W = 10;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic        clear = 1'b0;
  logic        browse = 1'b0;
  logic        step = 1'b0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] write_data = 32'd0;

  logic [11:0] ow_addr_bcd, ow_data_bcd, nw_addr_bcd, nw_data_bcd;
  logic        ow_entry_valid, ow_overflow, ow_busy;
  logic        nw_entry_valid, nw_overflow, nw_busy;
  logic [3:0]  ow_count, nw_count;

  store_trace_display #(.OVERWRITE(1)) dut_ow (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_addr(data_addr),
    .write_data(write_data), .clear(clear), .browse(browse), .step(step),
    .addr_bcd(ow_addr_bcd), .data_bcd(ow_data_bcd), .entry_valid(ow_entry_valid),
    .count(ow_count), .overflow(ow_overflow), .busy(ow_busy)
  );

  store_trace_display #(.OVERWRITE(0)) dut_nw (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_addr(data_addr),
    .write_data(write_data), .clear(clear), .browse(browse), .step(step),
    .addr_bcd(nw_addr_bcd), .data_bcd(nw_data_bcd), .entry_valid(nw_entry_valid),
    .count(nw_count), .overflow(nw_overflow), .busy(nw_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: trace as queues (oldest first), display values per DUT.
  logic [9:0] qa0[$], qd0[$], qa1[$], qd1[$];
  bit         ov[2];
  int         off;
  bit         brs;
  logic [9:0] da[2], dd[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [9:0] v);
    int x;
    x = int'(v) % 1000;
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic model_reset();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    ov[0] = 0; ov[1] = 0; off = 0; brs = browse;
    da[0] = '0; dd[0] = '0; da[1] = '0; dd[1] = '0;
  endtask

  task automatic model_refresh(input int m);
    if (m == 0) begin
      if (qa0.size() == 0) begin da[0] = '0; dd[0] = '0; end
      else begin da[0] = qa0[qa0.size()-1-off]; dd[0] = qd0[qd0.size()-1-off]; end
    end else begin
      if (qa1.size() == 0) begin da[1] = '0; dd[1] = '0; end
      else begin da[1] = qa1[qa1.size()-1-off]; dd[1] = qd1[qd1.size()-1-off]; end
    end
  endtask

  task automatic model_store(input logic [9:0] a, input logic [9:0] d);
    qa0.push_back(a); qd0.push_back(d);
    if (qa0.size() > DEPTH) begin
      void'(qa0.pop_front()); void'(qd0.pop_front()); ov[0] = 1;
    end
    if (!brs) model_refresh(0);
    if (qa1.size() == DEPTH) ov[1] = 1;
    else begin
      qa1.push_back(a); qd1.push_back(d);
      if (!brs) model_refresh(1);
    end
  endtask

  task automatic model_step();
    if (brs && qa0.size() > 0) begin
      off = (off + 1) % qa0.size();
      model_refresh(0); model_refresh(1);
    end
  endtask

  task automatic model_browse(input bit nb);
    if (!nb) off = 0;
    if (brs && !nb) begin model_refresh(0); model_refresh(1); end
    brs = nb;
  endtask

  task automatic model_clear();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    ov[0] = 0; ov[1] = 0; off = 0;
    model_refresh(0); model_refresh(1);
  endtask

  // One-cycle pulse on the control inputs; returns at the negedge after the edge.
  task automatic drive(input bit mw, input bit cl, input bit st,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = mw; clear = cl; step = st; data_addr = a; write_data = d;
    @(negedge clk);
    mem_write = 1'b0; clear = 1'b0; step = 1'b0;
  endtask

  task automatic set_browse(input bit b);
    @(negedge clk);
    browse = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ow_busy || nw_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, (ow_busy || nw_busy)}, 32'd0);
  endtask

  task automatic check_all(input string tag);
    check({tag, " ow_count"}, ow_count, qa0.size());
    check({tag, " nw_count"}, nw_count, qa1.size());
    check({tag, " ow_ovf"}, ow_overflow, ov[0]);
    check({tag, " nw_ovf"}, nw_overflow, ov[1]);
    check({tag, " ow_valid"}, ow_entry_valid, qa0.size() != 0);
    check({tag, " nw_valid"}, nw_entry_valid, qa1.size() != 0);
    check({tag, " ow_addr"}, ow_addr_bcd, to_bcd(da[0]));
    check({tag, " ow_data"}, ow_data_bcd, to_bcd(dd[0]));
    check({tag, " nw_addr"}, nw_addr_bcd, to_bcd(da[1]));
    check({tag, " nw_data"}, nw_data_bcd, to_bcd(dd[1]));
  endtask

  logic [31:0] a, d;
  int          t0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    do_reset();
    check("rst_busy", ow_busy, 1'b0);
    check_all("rst");

    // First store and exact latency
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'd25);
    model_store(10'h040, 10'd25);
    repeat (CAP_W + 1) @(negedge clk);
    check("lat_pre_busy", ow_busy, 1'b1);
    check("lat_pre_addr", ow_addr_bcd, 12'h000);
    @(negedge clk);
    check("lat_addr", ow_addr_bcd, 12'h064);
    check("lat_data", ow_data_bcd, 12'h025);
    check("lat_busy", ow_busy, 1'b0);
    check_all("t1");

    // Ten stores: ring vs. stop-when-full, then browse
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'(i));
      model_store(10'(32'h100 + 32'(i * 4)), 10'(i));
    end
    wait_idle();
    check("t2_ow_count", ow_count, 4'd8);
    check("t2_ow_ovf", ow_overflow, 1'b1);
    check("t2_ow_live", ow_data_bcd, 12'h010);
    check("t2_nw_live", nw_data_bcd, 12'h008);
    check_all("t2");
    set_browse(1'b1); model_browse(1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0); model_step(); wait_idle();
    end
    check("t2_ow_step7", ow_data_bcd, 12'h003);
    check("t2_nw_step7", nw_data_bcd, 12'h001);
    drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0); model_step(); wait_idle();
    check("t2_ow_step8", ow_data_bcd, 12'h010);
    check("t2_nw_step8", nw_data_bcd, 12'h008);
    set_browse(1'b0); model_browse(1'b0); wait_idle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0); model_clear(); wait_idle();
    check("t2_clr_count", nw_count, 4'd0);
    check("t2_clr_ovf", nw_overflow, 1'b0);
    check("t2_clr_data", nw_data_bcd, 12'h000);
    check_all("t2c");

    // Three back-to-back stores during a conversion coalesce into one restart
    drive(1'b1, 1'b0, 1'b0, 32'd11, 32'd111);
    model_store(10'd11, 10'd111);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      mem_write = 1'b1; data_addr = 32'(200 + i); write_data = 32'(300 + i);
      model_store(10'(200 + i), 10'(300 + i));
      @(negedge clk);
    end
    mem_write = 1'b0;
    while ((ow_busy || nw_busy) && (cyc - t0) < 100) @(negedge clk);
    check("t3_busy_len", 32'(cyc - t0), 32'(2 * (CAP_W + 2)));
    check("t3_data", ow_data_bcd, 12'h302);
    check_all("t3");

    // Reset in the middle of SHIFT, then width truncation
    drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_busy", ow_busy, 1'b0);
    check("t4_data", ow_data_bcd, 12'h000);
    check("t4_addr", ow_addr_bcd, 12'h000);
    reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_03FF);
    model_store(10'h3FF, 10'h3FF);
    wait_idle();
    check("t4_addr_trunc", ow_addr_bcd, 12'h023);
    check("t4_data_trunc", ow_data_bcd, 12'h023);
    check_all("t4");

    // clear + store together; step on an empty trace does nothing
    drive(1'b1, 1'b1, 1'b0, 32'd5, 32'd6); model_clear(); wait_idle();
    check("t5_count", ow_count, 4'd0);
    set_browse(1'b1); model_browse(1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0); model_step();
    check("t5_no_conv", {31'd0, ow_busy | nw_busy}, 32'd0);
    set_browse(1'b0); model_browse(1'b0); wait_idle();
    check_all("t5");

    // Randomised operations against the model
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      a = $urandom; d = $urandom;
      if (r < 45) begin
        drive(1'b1, 1'b0, 1'b0, a, d); model_store(a[9:0], d[9:0]);
      end else if (r < 72) begin
        drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0); model_step();
      end else if (r < 90) begin
        set_browse(~browse); model_browse(browse);
      end else if (r < 95) begin
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0); model_clear();
      end else begin
        drive(1'b1, 1'b1, 1'b0, a, d); model_clear();
      end
      wait_idle();
      check_all($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
